// File: rtl/drp_seq_pkg.sv
// Shared types and constants for the DRP reconfiguration sequencer.
// Table entries are packed as {addr, mask, data}; mask bit 1 keeps the current register bit.
package drp_seq_pkg;

  localparam int DRP_AW   = 7;
  localparam int DRP_DW   = 16;
  localparam int TBL_DW   = 39;

  localparam int ADDR_MSB = 38;
  localparam int ADDR_LSB = 32;
  localparam int MASK_MSB = 31;
  localparam int MASK_LSB = 16;
  localparam int DATA_MSB = 15;

  typedef enum logic [3:0] {
    S_IDLE,
    S_HOLD_RST,
    S_FETCH,
    S_LATCH,
    S_RD_REQ,
    S_RD_WAIT,
    S_WR_REQ,
    S_WR_WAIT,
    S_NEXT,
    S_WAIT_LOCK,
    S_FINISH
  } seq_state_e;

  function automatic logic [DRP_DW-1:0] rmw_merge(
    input logic [DRP_DW-1:0] cur,
    input logic [DRP_DW-1:0] mask,
    input logic [DRP_DW-1:0] data
  );
    return (cur & mask) | (data & ~mask);
  endfunction

endpackage

// File: rtl/drp_access.sv
// One DRP access: a single-cycle DEN strobe, then a bounded wait for DRDY.
// DRDY counts only from the cycle after the strobe; the read data is held until the next completion.
module drp_access
  import drp_seq_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic              DCLK,
  input  logic              RST_N,
  input  logic              strobe,
  input  logic              we,
  input  logic [DRP_DW-1:0] drp_do,
  input  logic              drdy,
  output logic              den,
  output logic              dwe,
  output logic              done,
  output logic              timeout,
  output logic [DRP_DW-1:0] rdata
);

  localparam int TW = $clog2(TIMEOUT + 1);

  logic              pend_q, pend_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [DRP_DW-1:0] rdata_q, rdata_d;

  always_comb begin
    pend_d  = pend_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    den     = strobe;
    dwe     = strobe & we;
    done    = pend_q & drdy;
    // The last allowed wait cycle without DRDY ends the access.
    timeout = pend_q & ~drdy & (cnt_q == TW'(TIMEOUT - 1));
    if (strobe) begin
      pend_d = 1'b1;
      cnt_d  = '0;
    end else if (pend_q) begin
      if (drdy) begin
        pend_d  = 1'b0;
        rdata_d = drp_do;
      end else if (timeout) begin
        pend_d = 1'b0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_q  <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/drp_reconf_seq.sv
// DRP master: holds the PLL in reset, read-modify-writes COUNT table entries from BASE,
// then waits for LOCKED and reports DONE (1-cycle pulse) or a sticky ERROR on any timeout.
module drp_reconf_seq
  import drp_seq_pkg::*;
#(
  parameter int TBL_AW       = 5,
  parameter int RST_HOLD     = 4,
  parameter int DRDY_TIMEOUT = 1024,
  parameter int LOCK_TIMEOUT = 65535
) (
  input  logic              DCLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [TBL_AW-1:0] BASE,
  input  logic [TBL_AW:0]   COUNT,
  output logic [TBL_AW-1:0] TBL_INDEX,
  input  logic [TBL_DW-1:0] TBL_DATA,
  output logic [DRP_AW-1:0] DADDR,
  output logic              DEN,
  output logic              DWE,
  output logic [DRP_DW-1:0] DI,
  input  logic [DRP_DW-1:0] DO,
  input  logic              DRDY,
  output logic              PLL_RST,
  input  logic              LOCKED,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERROR
);

  localparam int TMR_MAX = (LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  seq_state_e        state_q, state_d;
  logic [TBL_AW-1:0] base_q, base_d;
  logic [TBL_AW:0]   count_q, count_d, off_q, off_d, off_nxt;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [DRP_DW-1:0] mask_q, mask_d, data_q, data_d, di_q, di_d, wr_val;
  logic [DRP_AW-1:0] daddr_q, daddr_d;
  logic              err_q, err_d;
  logic              acc_strobe, acc_we, acc_done, acc_to;
  logic [DRP_DW-1:0] acc_rdata;

  drp_access #(.TIMEOUT(DRDY_TIMEOUT)) u_access (
    .DCLK    (DCLK),
    .RST_N   (RST_N),
    .strobe  (acc_strobe),
    .we      (acc_we),
    .drp_do  (DO),
    .drdy    (DRDY),
    .den     (DEN),
    .dwe     (DWE),
    .done    (acc_done),
    .timeout (acc_to),
    .rdata   (acc_rdata)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    count_d    = count_q;
    off_d      = off_q;
    mask_d     = mask_q;
    data_d     = data_q;
    daddr_d    = daddr_q;
    di_d       = di_q;
    err_d      = err_q;
    tmr_d      = tmr_q + 1'b1;
    acc_strobe = 1'b0;
    acc_we     = 1'b0;
    off_nxt    = off_q + 1'b1;
    wr_val     = rmw_merge(acc_rdata, mask_q, data_q);
    PLL_RST    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (START) begin
          base_d  = BASE;
          count_d = COUNT;
          off_d   = '0;
          err_d   = 1'b0;
          state_d = S_HOLD_RST;
        end
      end
      S_HOLD_RST: begin
        PLL_RST = 1'b1;
        if (tmr_q == TMR_W'(RST_HOLD - 1)) begin
          state_d = (count_q == '0) ? S_WAIT_LOCK : S_FETCH;
        end
      end
      S_FETCH: begin
        PLL_RST = 1'b1;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        PLL_RST = 1'b1;
        daddr_d = TBL_DATA[ADDR_MSB:ADDR_LSB];
        mask_d  = TBL_DATA[MASK_MSB:MASK_LSB];
        data_d  = TBL_DATA[DATA_MSB:0];
        state_d = S_RD_REQ;
      end
      S_RD_REQ: begin
        PLL_RST    = 1'b1;
        acc_strobe = 1'b1;
        state_d    = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        PLL_RST = 1'b1;
        if (acc_done) begin
          state_d = S_WR_REQ;
        end else if (acc_to) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_WR_REQ: begin
        PLL_RST    = 1'b1;
        acc_strobe = 1'b1;
        acc_we     = 1'b1;
        di_d       = wr_val;
        state_d    = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        PLL_RST = 1'b1;
        if (acc_done) begin
          state_d = S_NEXT;
        end else if (acc_to) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_NEXT: begin
        // Release the PLL as soon as the final write has completed.
        PLL_RST = (off_nxt != count_q);
        off_d   = off_nxt;
        state_d = (off_nxt == count_q) ? S_WAIT_LOCK : S_FETCH;
      end
      S_WAIT_LOCK: begin
        if (LOCKED) begin
          state_d = S_FINISH;
        end else if (tmr_q == TMR_W'(LOCK_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d != state_q) begin
      tmr_d = '0;
    end

    TBL_INDEX = base_q + off_q[TBL_AW-1:0];
    DADDR     = daddr_q;
    // The merged value is presented during the write strobe, then held.
    DI        = (state_q == S_WR_REQ) ? wr_val : di_q;
    BUSY      = (state_q != S_IDLE) && (state_q != S_FINISH);
    DONE      = (state_q == S_FINISH);
    ERROR     = err_q;
  end

  always_ff @(posedge DCLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      count_q <= '0;
      off_q   <= '0;
      tmr_q   <= '0;
      mask_q  <= '0;
      data_q  <= '0;
      daddr_q <= '0;
      di_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      count_q <= count_d;
      off_q   <= off_d;
      tmr_q   <= tmr_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      daddr_q <= daddr_d;
      di_q    <= di_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_drp_reconf_seq.sv
// Bench for drp_reconf_seq: table, DRP register file and PLL models with randomized latencies.
module tb_drp_reconf_seq;

  localparam int DTO  = 16;
  localparam int LTO  = 40;
  localparam int HOLD = 4;

  logic        DCLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        START = 1'b0;
  logic [4:0]  BASE = '0;
  logic [5:0]  COUNT = '0;
  logic [4:0]  TBL_INDEX;
  logic [38:0] TBL_DATA = '0;
  logic [6:0]  DADDR;
  logic        DEN, DWE;
  logic [15:0] DI;
  logic [15:0] DO = '0;
  logic        DRDY = 1'b0;
  logic        PLL_RST;
  logic        LOCKED = 1'b0;
  logic        BUSY, DONE, ERROR;

  drp_reconf_seq #(
    .TBL_AW(5), .RST_HOLD(HOLD), .DRDY_TIMEOUT(DTO), .LOCK_TIMEOUT(LTO)
  ) dut (
    .DCLK(DCLK), .RST_N(RST_N), .START(START), .BASE(BASE), .COUNT(COUNT),
    .TBL_INDEX(TBL_INDEX), .TBL_DATA(TBL_DATA), .DADDR(DADDR), .DEN(DEN),
    .DWE(DWE), .DI(DI), .DO(DO), .DRDY(DRDY), .PLL_RST(PLL_RST),
    .LOCKED(LOCKED), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR)
  );

  always #5 DCLK = ~DCLK;

  int total = 0;
  int bad = 0;

  logic [38:0] tbl [32];
  logic [15:0] regs [128];
  logic [22:0] wr_q [$];
  logic [6:0]  rd_q [$];
  int          idx_q [$];

  bit drdy_en = 1'b1;
  bit spur = 1'b0;
  bit lock_en = 1'b1;
  int drdy_min = 1;
  int drdy_max = 3;
  int lock_dly = 5;
  int done_cnt = 0;
  int pll_hi = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Synchronous table, DRP register file and PLL, all acting on the falling edge.
  logic [4:0] idx_s = '0;
  bit         pend = 1'b0;
  int         dly = 0;
  int         lcnt = 0;
  logic       den_prev = 1'b0;
  always @(negedge DCLK) begin
    TBL_DATA = tbl[idx_s];
    idx_s    = TBL_INDEX;
    DRDY     = 1'b0;
    if (!RST_N || !drdy_en) begin
      pend = 1'b0;
    end else if (pend) begin
      dly--;
      if (dly <= 0) begin
        DRDY = 1'b1;
        pend = 1'b0;
      end
    end
    if (DEN) begin
      chk("den_one_cycle", 32'(den_prev), 32'd0);
      chk("pll_rst_at_strobe", 32'(PLL_RST), 32'd1);
      if (DWE) begin
        wr_q.push_back({DADDR, DI});
        regs[DADDR] = DI;
        DO = 16'($urandom);
      end else begin
        rd_q.push_back(DADDR);
        idx_q.push_back(int'(TBL_INDEX));
        DO = regs[DADDR];
      end
      pend = drdy_en;
      dly  = $urandom_range(drdy_min, drdy_max);
      if (spur) DRDY = 1'b1;
    end
    den_prev = DEN;
    if (PLL_RST) begin
      LOCKED = 1'b0;
      lcnt   = 0;
      pll_hi++;
    end else if (lock_en) begin
      lcnt++;
      if (lcnt >= lock_dly) LOCKED = 1'b1;
    end else begin
      LOCKED = 1'b0;
    end
    if (DONE) done_cnt++;
  end

  task automatic fill_rand();
    logic [63:0] r;
    for (int i = 0; i < 32; i++) begin
      r = {$urandom, $urandom};
      tbl[i] = r[38:0];
    end
    for (int i = 0; i < 128; i++) regs[i] = 16'($urandom);
  endtask

  task automatic pulse_start(input int base, input int cnt);
    @(negedge DCLK);
    BASE  = 5'(base);
    COUNT = 6'(cnt);
    START = 1'b1;
    @(negedge DCLK);
    START = 1'b0;
    BASE  = 5'($urandom);
    COUNT = 6'($urandom);
  endtask

  // Successful sequence, checked against an entry-by-entry read-modify-write model.
  task automatic run_seq(input int base, input int cnt, input bit extra_start);
    logic [15:0] mreg [128];
    logic [22:0] exp_w [$];
    logic [6:0]  exp_r [$];
    int          exp_i [$];
    logic [38:0] ent;
    logic [6:0]  a;
    logic [15:0] m, d;
    int          d0, k, ix;
    for (int i = 0; i < 128; i++) mreg[i] = regs[i];
    for (int e = 0; e < cnt; e++) begin
      ix  = (base + e) % 32;
      ent = tbl[ix];
      a   = ent[38:32];
      m   = ent[31:16];
      d   = ent[15:0];
      mreg[a] = (mreg[a] & m) | (d & ~m);
      exp_r.push_back(a);
      exp_i.push_back(ix);
      exp_w.push_back({a, mreg[a]});
    end
    wr_q.delete();
    rd_q.delete();
    idx_q.delete();
    d0 = done_cnt;
    pulse_start(base, cnt);
    chk("busy_after_start", 32'(BUSY), 32'd1);
    chk("error_clr_on_start", 32'(ERROR), 32'd0);
    for (k = 0; k < 4000; k++) begin
      @(negedge DCLK);
      START = extra_start && (k == 8);
      if (!BUSY) break;
    end
    chk("seq_ends", 32'(k < 4000), 32'd1);
    chk("finish_done", 32'(DONE), 32'd1);
    chk("finish_error", 32'(ERROR), 32'd0);
    START = 1'b1;
    @(negedge DCLK);
    START = 1'b0;
    chk("start_in_finish_ignored", 32'(BUSY), 32'd0);
    chk("done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("n_writes", 32'(wr_q.size()), 32'(exp_w.size()));
    chk("n_reads", 32'(rd_q.size()), 32'(exp_r.size()));
    for (int i = 0; i < exp_w.size() && i < wr_q.size(); i++)
      chk("write", 32'(wr_q[i]), 32'(exp_w[i]));
    for (int i = 0; i < exp_r.size() && i < rd_q.size(); i++) begin
      chk("read_addr", 32'(rd_q[i]), 32'(exp_r[i]));
      chk("tbl_index", 32'(idx_q[i]), 32'(exp_i[i]));
    end
  endtask

  initial begin
    int k, p0, d0, n0;
    for (int i = 0; i < 128; i++) regs[i] = 16'hFFFF;
    for (int i = 0; i < 32; i++) tbl[i] = '0;
    #1;
    chk("rst_ctrl", 32'({DEN, DWE, PLL_RST, BUSY, DONE, ERROR}), 32'd0);
    chk("rst_daddr", 32'(DADDR), 32'd0);
    chk("rst_di", 32'(DI), 32'd0);
    chk("rst_tbl_index", 32'(TBL_INDEX), 32'd0);
    repeat (2) @(negedge DCLK);
    RST_N = 1'b1;
    @(negedge DCLK);

    // Single entry against an all-ones register.
    tbl[0] = {7'h08, 16'h1000, 16'h6183};
    run_seq(0, 1, 1'b0);
    chk("t1_write", (wr_q.size() == 1) ? 32'(wr_q[0]) : 32'hDEAD, 32'({7'h08, 16'h7183}));

    // Two entries from BASE=3.
    for (int i = 0; i < 128; i++) regs[i] = 16'hA5A5;
    tbl[3] = {7'h08, 16'h0000, 16'h6183};
    tbl[4] = {7'h09, 16'hFC00, 16'h0083};
    run_seq(3, 2, 1'b0);
    chk("t2_write0", (wr_q.size() == 2) ? 32'(wr_q[0]) : 32'hDEAD, 32'({7'h08, 16'h6183}));
    chk("t2_write1", (wr_q.size() == 2) ? 32'(wr_q[1]) : 32'hDEAD, 32'({7'h09, 16'hA483}));
    chk("t2_index0", (idx_q.size() == 2) ? 32'(idx_q[0]) : 32'hDEAD, 32'd3);
    chk("t2_index1", (idx_q.size() == 2) ? 32'(idx_q[1]) : 32'hDEAD, 32'd4);

    // COUNT=0: only the reset hold, then lock.
    p0 = pll_hi;
    run_seq(9, 0, 1'b0);
    chk("cnt0_pll_hold", 32'(pll_hi - p0), 32'(HOLD));

    // DRDY never arrives.
    drdy_en = 1'b0;
    wr_q.delete();
    d0 = done_cnt;
    pulse_start(0, 1);
    for (k = 0; k < 50 && !DEN; k++) @(negedge DCLK);
    chk("to_read_strobe", 32'(DEN), 32'd1);
    for (k = 0; k < 100 && !ERROR; k++) @(negedge DCLK);
    chk("drdy_timeout_cycles", 32'(k), 32'(DTO + 1));
    chk("drdy_to_busy", 32'(BUSY), 32'd0);
    chk("drdy_to_pll_rst", 32'(PLL_RST), 32'd0);
    @(negedge DCLK);
    chk("drdy_to_no_done", 32'(done_cnt - d0), 32'd0);
    chk("drdy_to_no_write", 32'(wr_q.size()), 32'd0);
    drdy_en = 1'b1;
    fill_rand();
    run_seq(30, 4, 1'b0);

    // START while BUSY must not restart or extend the sequence.
    fill_rand();
    run_seq(7, 5, 1'b1);

    // LOCKED never arrives.
    lock_en = 1'b0;
    d0 = done_cnt;
    pulse_start(0, 0);
    for (k = 0; k < 50 && PLL_RST; k++) @(negedge DCLK);
    chk("lock_to_hold_len", 32'(k), 32'(HOLD));
    for (k = 0; k < 200 && !ERROR; k++) @(negedge DCLK);
    chk("lock_timeout_cycles", 32'(k), 32'(LTO));
    chk("lock_to_busy", 32'(BUSY), 32'd0);
    @(negedge DCLK);
    chk("lock_to_no_done", 32'(done_cnt - d0), 32'd0);
    lock_en = 1'b1;

    // Asynchronous reset while waiting for a write to complete.
    drdy_min = 6;
    drdy_max = 6;
    pulse_start(0, 2);
    for (k = 0; k < 200 && !(DEN && DWE); k++) @(negedge DCLK);
    chk("rst_mid_wr_strobe", 32'(DEN && DWE), 32'd1);
    @(negedge DCLK);
    #2 RST_N = 1'b0;
    #1;
    chk("rst_mid_ctrl", 32'({DEN, DWE, PLL_RST, BUSY}), 32'd0);
    n0 = wr_q.size() + rd_q.size();
    repeat (3) @(negedge DCLK);
    RST_N = 1'b1;
    repeat (3) @(negedge DCLK);
    chk("rst_mid_no_strobe", 32'(wr_q.size() + rd_q.size()), 32'(n0));
    chk("rst_mid_idle", 32'(BUSY), 32'd0);
    drdy_min = 1;
    drdy_max = 3;
    run_seq(12, 3, 1'b0);

    // Randomized tables, register contents and handshake latencies.
    for (int it = 0; it < 12; it++) begin
      fill_rand();
      drdy_max = $urandom_range(1, 4);
      spur     = 1'($urandom_range(0, 1));
      lock_dly = $urandom_range(1, 8);
      run_seq($urandom_range(0, 31), (it == 5) ? 32 : $urandom_range(1, 8), (it % 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/drp_reconf_seq.md
Name: drp_reconf_seq

Overview:
Upstream DRP master for the dynamic reconfiguration register block. It drives the block's DADDR/DEN/DWE/DI and consumes its DO/DRDY. On START it walks a table of {address, mask, data} entries and performs one read-modify-write per entry. Around the sequence it holds the PLL in reset, then waits for LOCKED and reports DONE or ERROR.

Parameters:
TBL_AW, 5, table index width; up to 2^TBL_AW entries
RST_HOLD, 4, DCLK cycles PLL_RST is held before the first DRP access
DRDY_TIMEOUT, 1024, maximum DCLK cycles to wait for DRDY per access
LOCK_TIMEOUT, 65535, maximum DCLK cycles to wait for LOCKED after PLL_RST release

Ports:
DCLK  in  1  DRP clock; the only clock
RST_N  in  1  asynchronous, active-low reset
START  in  1  1-cycle request; ignored while BUSY=1
BASE  in  TBL_AW  first table index; sampled on START
COUNT  in  TBL_AW+1  number of entries; sampled on START; 0 = no DRP accesses
TBL_INDEX  out  TBL_AW  table read address
TBL_DATA  in  39  {addr[38:32], mask[31:16], data[15:0]}; valid 1 cycle after TBL_INDEX
DADDR  out  7  DRP address
DEN  out  1  DRP enable
DWE  out  1  DRP write enable
DI  out  16  DRP write data
DO  in  16  DRP read data
DRDY  in  1  DRP access complete
PLL_RST  out  1  reset to the PLL model
LOCKED  in  1  PLL lock indicator
BUSY  out  1  sequence in progress
DONE  out  1  1-cycle pulse on successful completion
ERROR  out  1  sticky; cleared by the next accepted START

Behaviour:
- Reset (async, RST_N=0): state IDLE; all outputs 0, including DEN, DWE, PLL_RST, DADDR, DI and TBL_INDEX. Reset mid-sequence aborts immediately with no further DRP strobes.
- States and transitions:
  - IDLE: on START, latch BASE/COUNT, clear ERROR, set BUSY, go to HOLD_RST.
  - HOLD_RST: PLL_RST=1 for RST_HOLD cycles. Then go to FETCH, or to WAIT_LOCK if COUNT=0.
  - FETCH: drive TBL_INDEX = BASE + entry offset (wraps mod 2^TBL_AW).
  - LATCH: capture TBL_DATA.
  - RD_REQ: 1 cycle with DEN=1, DWE=0, DADDR=addr.
  - RD_WAIT: on DRDY=1, capture DO.
  - WR_REQ: 1 cycle with DEN=1, DWE=1, DI = (DO_cap & mask) | (data & ~mask). Mask bit 1 keeps the existing bit.
  - WR_WAIT: on DRDY=1, go to NEXT.
  - NEXT: increment the entry counter; return to FETCH until COUNT entries are done, else go to WAIT_LOCK.
  - WAIT_LOCK: PLL_RST=0; on LOCKED=1 go to FINISH.
  - FINISH: DONE=1 for one cycle, BUSY=0, go to IDLE.
- DRDY handling:
  - DRDY is sampled only from the cycle after the DEN strobe. A DRDY level present during RD_REQ/WR_REQ is ignored.
  - Exactly one DEN strobe per access. DEN is never asserted while waiting.
- Timeouts:
  - DRDY not seen within DRDY_TIMEOUT cycles: set ERROR, release PLL_RST, BUSY=0, go to IDLE. No DONE pulse.
  - LOCKED not seen within LOCK_TIMEOUT cycles: same handling.
  - Timeout counters reset on every state entry.
- PLL_RST is 1 from HOLD_RST through the last WR_WAIT, and 0 otherwise.
- DADDR and DI hold their last values between strobes.
- START arriving together with FINISH is ignored.
- COUNT = 2^TBL_AW is legal; the index wraps to BASE after the last entry.

Decomposition:
- Package drp_seq_pkg holds:
  - the state enum;
  - table field offsets (ADDR_MSB=38, ADDR_LSB=32, MASK_MSB=31, MASK_LSB=16, DATA_MSB=15);
  - the DRP address width (7) and data width (16).
- One sub-module, drp_access. It performs a single read or write strobe plus the DRDY wait with timeout, and returns done/timeout and the read data. The top-level FSM sequences it.

Test Plan:
- Single entry {0x08, 0x1000, 0x6183}, model DO=0xFFFF -> one read then one write of DI=0x7183 to DADDR 0x08. PLL_RST is high throughout. LOCKED raised 5 cycles after release -> DONE pulse, ERROR=0.
- COUNT=2, BASE=3, entries {0x08,0x0000,0x6183} and {0x09,0xFC00,0x0083}, DO=0xA5A5 -> writes 0x6183 then 0xA483, in order, with TBL_INDEX 3 then 4.
- COUNT=0 -> no DEN strobe; PLL_RST high for RST_HOLD=4 cycles then low; DONE after LOCKED.
- DRDY held low with DRDY_TIMEOUT=16 -> ERROR=1 after 16 cycles of RD_WAIT, PLL_RST=0, BUSY=0, no DONE. A following START clears ERROR.
- START pulsed while BUSY -> ignored: exactly COUNT read/write pairs are issued.
- RST_N low during WR_WAIT -> DEN, DWE, PLL_RST and BUSY drop to 0 immediately; after release the block is in IDLE and accepts a new START.
